screen_mirror: RTL and testbench
================================

Name: screen_mirror

Overview:
- Shadow frame store for the 160x120, 3-bit-colour display.
- Sits upstream of the screen slider: supplies its read-back colour with a fixed 2-cycle read latency.
- Sits in the write path to the VGA adapter: every accepted pixel write is stored locally and forwarded to the adapter one cycle later.
- Provides a full-screen clear sequencer so the store and the display can be initialised together.

Parameters:
- X_MAX, 159, largest valid x coordinate.
- Y_MAX, 119, largest valid y coordinate.
- CLEAR_COLOUR, 3'b000, colour written by the clear sweep.

Ports:
- clock  in  1  system clock
- reset_n  in  1  reset
- x  in  8  write x coordinate
- y  in  7  write y coordinate
- writeColour  in  3  write colour
- writeEn  in  1  write strobe
- readX  in  8  read x coordinate
- readY  in  7  read y coordinate
- readColour  out  3  read data, 2 cycles after address
- clearStart  in  1  begin full-screen clear
- clearDone  out  1  high when no clear is in progress
- vgaX  out  8  forwarded x to VGA adapter
- vgaY  out  7  forwarded y to VGA adapter
- vgaColour  out  3  forwarded colour
- vgaWriteEn  out  1  forwarded write strobe

Behaviour:
- Clocking and reset: one clock, clock. reset_n is asynchronous and active-low.
- Reset values: readColour=0, vgaX=0, vgaY=0, vgaColour=0, vgaWriteEn=0, clearDone=1, FSM=IDLE, sweep counters=0.
- Storage: memory contents are not reset and are undefined at power-up. Software issues a clear after reset.
- Address: y*160+x, 15 bits, computed as (y<<7)+(y<<5)+x. One read port, one write port, 19200 x 3 bits.
- Valid coordinate: x<=X_MAX and y<=Y_MAX.
- Write path (IDLE):
  - writeEn=1 with a valid coordinate stores writeColour at the next edge.
  - The same edge registers vgaX/vgaY/vgaColour and sets vgaWriteEn=1 (1-cycle forward latency).
  - Out-of-range writes are dropped: nothing stored, vgaWriteEn=0.
  - With writeEn=0, vgaWriteEn=0 and vgaX/vgaY/vgaColour hold their last values.
- Read path:
  - readX/readY are registered at edge N.
  - Memory data is registered into readColour at edge N+1, so it is valid after edge N+1 (2 cycles after presentation).
  - Fully pipelined: a new address is accepted every cycle.
  - An out-of-range registered read address yields CLEAR_COLOUR.
  - Read and write to the same address on the same edge: read returns the old data (read-before-write).
- FSM states: IDLE, CLEARING.
- IDLE -> CLEARING:
  - Triggered by clearStart=1 at an edge.
  - Counters set to (0,0); clearDone drops to 0 on that edge.
- CLEARING:
  - One pixel per cycle: store CLEAR_COLOUR at (cx,cy) and forward it to VGA with vgaWriteEn=1, same 1-cycle latency.
  - Sweep order: cx increments; at cx==X_MAX it wraps to 0 and cy increments.
  - After (X_MAX,Y_MAX) is written, return to IDLE with clearDone=1. Total 19200 write cycles.
  - External writeEn is ignored for the whole clear: no store, no forward.
  - Reads remain serviced and may return partially cleared contents.
- clearStart during CLEARING restarts the sweep at (0,0).
- clearStart and writeEn in the same IDLE cycle: the clear takes priority and the write is dropped.
- Reset mid-clear: immediately IDLE, clearDone=1, vgaWriteEn=0. Memory is partially cleared.

Test Plan:
- Reset, pulse clearStart:
  - clearDone=0 for exactly 19200 cycles with vgaWriteEn=1 on each, first forward (0,0), last (159,119).
  - Afterwards reads of (0,0), (80,60) and (159,119) return 3'b000.
- Write (10,20) colour 5 at cycle T:
  - vgaX=10, vgaY=20, vgaColour=5, vgaWriteEn=1 after edge T+1 only.
  - readX=10, readY=20 presented at T+2 gives readColour=5 two cycles later.
- Write (160,5) and (3,120) colour 7:
  - vgaWriteEn stays 0.
  - Read-back of (3,5) is unchanged.
  - Read of (200,0) returns 0.
- Write (4,4)=6, then on one edge write (4,4)=2 and read (4,4):
  - That read returns 6.
  - The following read returns 2.
- clearStart, then writeEn (1,1)=3 at sweep cycle 100:
  - The write is dropped.
  - clearStart at sweep cycle 500 restarts the forward at (0,0); total clear length = 500+19200 cycles.
- Assert reset_n low at sweep cycle 1000, asynchronously mid-cycle:
  - clearDone=1 and vgaWriteEn=0 without waiting for a clock edge.
  - After release, writes are accepted normally.

Source files
------------

// File: rtl/screen_mirror_if.sv
// Pixel write, read-back, clear-control and VGA-forward signals of the screen mirror.
// The bench drives through master; the mirror itself uses slave.
interface screen_mirror_if;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] writeColour;
  logic       writeEn;
  logic [7:0] readX;
  logic [6:0] readY;
  logic [2:0] readColour;
  logic       clearStart;
  logic       clearDone;
  logic [7:0] vgaX;
  logic [6:0] vgaY;
  logic [2:0] vgaColour;
  logic       vgaWriteEn;

  // Strobe semantics, no backpressure: writeEn/clearStart are sampled on every
  // clock edge, and vgaWriteEn marks a one-cycle write toward the adapter.
  modport master (
    output x, y, writeColour, writeEn, readX, readY, clearStart,
    input  readColour, clearDone, vgaX, vgaY, vgaColour, vgaWriteEn
  );
  modport slave (
    input  x, y, writeColour, writeEn, readX, readY, clearStart,
    output readColour, clearDone, vgaX, vgaY, vgaColour, vgaWriteEn
  );
endinterface

// File: rtl/screen_mirror.sv
// Shadow frame store for the 160x120x3 display: forwards accepted writes to the
// VGA adapter, serves 2-cycle read-back, and sweeps a full-screen clear.
module screen_mirror #(
  parameter int         X_MAX        = 159,
  parameter int         Y_MAX        = 119,
  parameter logic [2:0] CLEAR_COLOUR = 3'b000
) (
  input  logic            clock,
  input  logic            reset_n,
  screen_mirror_if.slave  bus,
  output logic            dbg_state_o   // 1 while a clear sweep is running
);
  localparam int         DEPTH = (X_MAX + 1) * (Y_MAX + 1);
  localparam logic [7:0] XM    = 8'(X_MAX);
  localparam logic [6:0] YM    = 7'(Y_MAX);

  typedef enum logic {IDLE = 1'b0, CLEARING = 1'b1} state_e;

  state_e      state_q, state_d;
  logic [7:0]  cx_q, cx_d;
  logic [6:0]  cy_q, cy_d;
  logic        wr_en;
  logic [7:0]  wr_x;
  logic [6:0]  wr_y;
  logic [2:0]  wr_c;
  logic [14:0] rd_addr_q;
  logic        rd_ok_q;
  logic [2:0]  mem [DEPTH];

  // y*160 + x without a multiplier
  function automatic logic [14:0] pix_addr(input logic [7:0] px, input logic [6:0] py);
    logic [14:0] y15;
    y15 = {8'd0, py};
    return (y15 << 7) + (y15 << 5) + {7'd0, px};
  endfunction

  assign bus.clearDone = (state_q == IDLE);
  assign dbg_state_o   = state_q;

  always_comb begin
    state_d = state_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    wr_en   = 1'b0;
    wr_x    = bus.x;
    wr_y    = bus.y;
    wr_c    = bus.writeColour;
    case (state_q)
      IDLE: begin
        if (bus.clearStart) begin
          state_d = CLEARING;
          cx_d    = 8'd0;
          cy_d    = 7'd0;
        end else if (bus.writeEn && (bus.x <= XM) && (bus.y <= YM)) begin
          wr_en = 1'b1;
        end
      end
      CLEARING: begin
        wr_en = 1'b1;
        wr_c  = CLEAR_COLOUR;
        // A restart writes pixel (0,0) immediately and continues from (1,0).
        if (bus.clearStart) begin
          wr_x = 8'd0;
          wr_y = 7'd0;
          cx_d = 8'd1;
          cy_d = 7'd0;
        end else begin
          wr_x = cx_q;
          wr_y = cy_q;
          if (cx_q == XM) begin
            cx_d = 8'd0;
            if (cy_q == YM) begin
              cy_d    = 7'd0;
              state_d = IDLE;
            end else begin
              cy_d = cy_q + 7'd1;
            end
          end else begin
            cx_d = cx_q + 8'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      cx_q           <= 8'd0;
      cy_q           <= 7'd0;
      bus.vgaX       <= 8'd0;
      bus.vgaY       <= 7'd0;
      bus.vgaColour  <= 3'd0;
      bus.vgaWriteEn <= 1'b0;
      rd_addr_q      <= 15'd0;
      rd_ok_q        <= 1'b0;
      bus.readColour <= 3'd0;
    end else begin
      state_q        <= state_d;
      cx_q           <= cx_d;
      cy_q           <= cy_d;
      bus.vgaWriteEn <= wr_en;
      if (wr_en) begin
        bus.vgaX      <= wr_x;
        bus.vgaY      <= wr_y;
        bus.vgaColour <= wr_c;
      end
      rd_addr_q      <= pix_addr(bus.readX, bus.readY);
      rd_ok_q        <= (bus.readX <= XM) && (bus.readY <= YM);
      // Reads the array before this edge's write lands: read-before-write.
      bus.readColour <= rd_ok_q ? mem[rd_addr_q] : CLEAR_COLOUR;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem[pix_addr(wr_x, wr_y)] <= wr_c;
  end
endmodule

// File: tb/tb_screen_mirror.sv
// Bench for screen_mirror: a pixel-level frame model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_screen_mirror;
  logic clock;
  logic reset_n;
  logic dbg_state;
  int   n_total = 0;
  int   n_pass  = 0;

  screen_mirror_if bus ();

  screen_mirror dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- checking helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- frame model ----------------
  logic [2:0] m_mem   [19200];
  bit         m_known [19200];
  bit         m_clearing = 1'b0;
  int         m_pix      = 0;
  logic       e_we  = 1'b0;
  logic [7:0] e_vx  = 8'd0;
  logic [6:0] e_vy  = 7'd0;
  logic [2:0] e_vc  = 3'd0;
  logic [2:0] e_rd  = 3'd0;
  bit         e_rd_known = 1'b1;
  bit         p_valid    = 1'b0;
  int         p_x = 0;
  int         p_y = 0;

  task automatic m_store(input int px, input int py, input logic [2:0] c);
    m_mem[15'(py * 160 + px)]   = c;
    m_known[15'(py * 160 + px)] = 1'b1;
    e_we = 1'b1;
    e_vx = 8'(px);
    e_vy = 7'(py);
    e_vc = c;
  endtask

  initial begin
    for (int i = 0; i < 19200; i++) m_known[i] = 1'b0;
    forever begin
      @(posedge clock or negedge reset_n);
      if (!reset_n) begin
        m_clearing = 1'b0;
        m_pix      = 0;
        e_we = 1'b0; e_vx = 8'd0; e_vy = 7'd0; e_vc = 3'd0;
        e_rd = 3'd0; e_rd_known = 1'b1;
        p_valid = 1'b0;
      end else begin
        // readback of the address captured one edge ago, before this edge's write
        if (!p_valid) e_rd_known = 1'b0;
        else if (p_x > 159 || p_y > 119) begin
          e_rd = 3'd0; e_rd_known = 1'b1;
        end else begin
          e_rd       = m_mem[15'(p_y * 160 + p_x)];
          e_rd_known = m_known[15'(p_y * 160 + p_x)];
        end
        p_valid = 1'b1;
        p_x = int'(bus.readX);
        p_y = int'(bus.readY);
        e_we = 1'b0;
        if (m_clearing) begin
          if (bus.clearStart) m_pix = 0;
          m_store(m_pix % 160, m_pix / 160, 3'd0);
          m_pix++;
          if (m_pix == 19200) m_clearing = 1'b0;
        end else if (bus.clearStart) begin
          m_clearing = 1'b1;
          m_pix      = 0;
        end else if (bus.writeEn && bus.x <= 8'd159 && bus.y <= 7'd119) begin
          m_store(int'(bus.x), int'(bus.y), bus.writeColour);
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clock);
      check("cyc_clearDone", 32'(bus.clearDone), 32'(!m_clearing));
      check("cyc_state", 32'(dbg_state), 32'(m_clearing));
      check("cyc_vgaWriteEn", 32'(bus.vgaWriteEn), 32'(e_we));
      check("cyc_vgaX", 32'(bus.vgaX), 32'(e_vx));
      check("cyc_vgaY", 32'(bus.vgaY), 32'(e_vy));
      check("cyc_vgaColour", 32'(bus.vgaColour), 32'(e_vc));
      if (e_rd_known) check("cyc_readColour", 32'(bus.readColour), 32'(e_rd));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_write(input logic [7:0] wx, input logic [6:0] wy, input logic [2:0] wc);
    bus.x = wx; bus.y = wy; bus.writeColour = wc; bus.writeEn = 1'b1;
    tick();
    bus.writeEn = 1'b0;
  endtask

  task automatic do_read(input logic [7:0] rx, input logic [6:0] ry,
                         input logic [2:0] exp, input string nm);
    bus.readX = rx; bus.readY = ry;
    tick();
    tick();
    check(nm, 32'(bus.readColour), 32'(exp));
  endtask

  // ---------------- directed sequence ----------------
  int lo, wc, k;
  int fx, fy, lx, ly;
  bit first_seen;

  initial begin
    reset_n = 1'b0;
    bus.x = 8'd0; bus.y = 7'd0; bus.writeColour = 3'd0; bus.writeEn = 1'b0;
    bus.readX = 8'd0; bus.readY = 7'd0; bus.clearStart = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_readColour", 32'(bus.readColour), 0);
    check("rst_vgaX", 32'(bus.vgaX), 0);
    check("rst_vgaWriteEn", 32'(bus.vgaWriteEn), 0);
    check("rst_clearDone", 32'(bus.clearDone), 1);
    @(negedge clock);
    #2 reset_n = 1'b1;
    tick();

    // full clear
    bus.clearStart = 1'b1;
    tick();
    bus.clearStart = 1'b0;
    check("clr_done_drop", 32'(bus.clearDone), 0);
    lo = 0; wc = 0; first_seen = 1'b0; fx = -1; fy = -1; lx = -1; ly = -1;
    while (bus.clearDone == 1'b0 && lo < 25000) begin
      lo++;
      tick();
      if (bus.vgaWriteEn) begin
        wc++;
        if (!first_seen) begin fx = int'(bus.vgaX); fy = int'(bus.vgaY); first_seen = 1'b1; end
        lx = int'(bus.vgaX); ly = int'(bus.vgaY);
      end
    end
    check("clr_low_cycles", 32'(lo), 19200);
    check("clr_we_cycles", 32'(wc), 19200);
    check("clr_first_x", 32'(fx), 0);
    check("clr_first_y", 32'(fy), 0);
    check("clr_last_x", 32'(lx), 159);
    check("clr_last_y", 32'(ly), 119);
    tick();
    check("clr_we_after", 32'(bus.vgaWriteEn), 0);
    do_read(8'd0, 7'd0, 3'd0, "clr_rd_0_0");
    do_read(8'd80, 7'd60, 3'd0, "clr_rd_80_60");
    do_read(8'd159, 7'd119, 3'd0, "clr_rd_159_119");

    // single write forwarded one cycle later, then read back
    check("wr_we_before", 32'(bus.vgaWriteEn), 0);
    do_write(8'd10, 7'd20, 3'd5);
    check("wr_vgaX", 32'(bus.vgaX), 10);
    check("wr_vgaY", 32'(bus.vgaY), 20);
    check("wr_vgaColour", 32'(bus.vgaColour), 5);
    check("wr_vgaWriteEn", 32'(bus.vgaWriteEn), 1);
    tick();
    check("wr_we_single", 32'(bus.vgaWriteEn), 0);
    check("wr_vga_hold", 32'(bus.vgaX), 10);
    do_read(8'd10, 7'd20, 3'd5, "wr_readback");

    // out-of-range writes and reads
    do_write(8'd3, 7'd5, 3'd1);
    do_write(8'd160, 7'd5, 3'd7);
    check("oor_x_we", 32'(bus.vgaWriteEn), 0);
    do_write(8'd3, 7'd120, 3'd7);
    check("oor_y_we", 32'(bus.vgaWriteEn), 0);
    do_read(8'd3, 7'd5, 3'd1, "oor_rd_3_5");
    do_read(8'd200, 7'd0, 3'd0, "oor_rd_200_0");

    // read-before-write collision
    do_write(8'd4, 7'd4, 3'd6);
    bus.readX = 8'd4; bus.readY = 7'd4;
    tick();
    do_write(8'd4, 7'd4, 3'd2);
    check("rbw_old", 32'(bus.readColour), 6);
    tick();
    check("rbw_new", 32'(bus.readColour), 2);

    // clear with a dropped write and a restart
    bus.clearStart = 1'b1;
    tick();
    bus.clearStart = 1'b0;
    k = 0; wc = 0;
    while (bus.clearDone == 1'b0 && k < 25000) begin
      if (k == 100) begin
        bus.x = 8'd1; bus.y = 7'd1; bus.writeColour = 3'd3; bus.writeEn = 1'b1;
      end
      if (k == 500) bus.clearStart = 1'b1;
      tick();
      bus.writeEn = 1'b0;
      bus.clearStart = 1'b0;
      if (bus.vgaWriteEn) wc++;
      if (k == 100) begin
        check("drop_vgaX", 32'(bus.vgaX), 100);
        check("drop_vgaY", 32'(bus.vgaY), 0);
        check("drop_vgaColour", 32'(bus.vgaColour), 0);
      end
      if (k == 500) begin
        check("restart_vgaX", 32'(bus.vgaX), 0);
        check("restart_vgaY", 32'(bus.vgaY), 0);
      end
      k++;
    end
    check("restart_len", 32'(k), 19700);
    check("restart_we_cycles", 32'(wc), 19700);
    do_read(8'd1, 7'd1, 3'd0, "drop_rd_1_1");

    // asynchronous reset in the middle of a clear
    bus.clearStart = 1'b1;
    tick();
    bus.clearStart = 1'b0;
    repeat (1000) tick();
    #2 reset_n = 1'b0;
    #1;
    check("areset_clearDone", 32'(bus.clearDone), 1);
    check("areset_vgaWriteEn", 32'(bus.vgaWriteEn), 0);
    repeat (2) @(posedge clock);
    #3 reset_n = 1'b1;
    tick();
    do_write(8'd7, 7'd7, 3'd4);
    check("post_rst_vgaX", 32'(bus.vgaX), 7);
    check("post_rst_vgaColour", 32'(bus.vgaColour), 4);
    check("post_rst_we", 32'(bus.vgaWriteEn), 1);
    do_read(8'd7, 7'd7, 3'd4, "post_rst_rd");
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
